max7219_chain_if: RTL and testbench

//   Parametrised serial driver for a daisy-chain of G_NB_DEVICES MAX7219 devices.

---
 rtl/max7219_chain_if.sv | 162 ++++++++++++++++
 tb/tb_max7219_chain_if.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_chain_if.sv
// Serial driver for a daisy-chain of MAX7219 devices.
// Shifts 16 bits per active device, MSB first, on DIN/CLK. The farthest active
// device's word goes out first. An optional LOAD pulse after the last bit latches
// all devices together.
//
// Ports:
//   clk, rst_n      system clock (rising edge) and async active-low reset
//   i_start         one-cycle frame request, only honoured while idle
//   i_en_load       pulse LOAD after the shift (captured with i_start)
//   i_nb_dev        active device count; 0 or out of range selects the whole chain
//   i_data          frame; device k (0 = nearest DIN) in bits [16k+15:16k]
//   o_max7219_load  LOAD/CS pin
//   o_max7219_data  DIN pin
//   o_max7219_clk   CLK pin
//   o_busy          frame in progress
//   o_done          one-cycle pulse when the frame is finished
module max7219_chain_if #(
  parameter int unsigned G_NB_DEVICES      = 4,
  parameter int unsigned G_MAX_HALF_PERIOD = 4,
  parameter int unsigned G_LOAD_DURATION   = 4,
  localparam int unsigned NB_BITS          = 16 * G_NB_DEVICES,
  localparam int unsigned NB_W             = $clog2(G_NB_DEVICES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_en_load,
  input  logic [NB_W-1:0]    i_nb_dev,
  input  logic [NB_BITS-1:0] i_data,
  output logic               o_max7219_load,
  output logic               o_max7219_data,
  output logic               o_max7219_clk,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned MAX_CNT = (G_MAX_HALF_PERIOD > G_LOAD_DURATION) ?
                                    G_MAX_HALF_PERIOD : G_LOAD_DURATION;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  // 16 * n fits in NB_W + 4 bits because n < 2**NB_W.
  localparam int unsigned BCNT_W  = NB_W + 4;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(G_MAX_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(G_LOAD_DURATION - 1);
  localparam logic [NB_W-1:0]  NB_MAX    = NB_W'(G_NB_DEVICES);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLoad,
    StDone
  } state_e;

  state_e              state;
  logic [NB_BITS-1:0]  shift_reg;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]    tick_cnt;
  logic                en_load;

  logic [NB_W-1:0]     nb_clamp;
  logic [NB_BITS-1:0]  shift_init;

  // Left-justify the active part so bit [16n-1] sits at the MSB; inactive upper
  // words fall off the top and are never sent.
  always_comb begin
    nb_clamp = i_nb_dev;
    if (i_nb_dev == '0 || i_nb_dev > NB_MAX) begin
      nb_clamp = NB_MAX;
    end
    shift_init = i_data << {NB_MAX - nb_clamp, 4'b0000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      tick_cnt       <= '0;
      en_load        <= 1'b0;
      o_max7219_load <= 1'b0;
      o_max7219_data <= 1'b0;
      o_max7219_clk  <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          if (i_start) begin
            shift_reg      <= shift_init;
            bit_cnt        <= {nb_clamp, 4'b0000};
            en_load        <= i_en_load;
            tick_cnt       <= '0;
            o_busy         <= 1'b1;
            o_max7219_clk  <= 1'b0;
            o_max7219_data <= shift_init[NB_BITS-1];
            state          <= StShiftLo;
          end
        end

        StShiftLo: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt      <= '0;
            o_max7219_clk <= 1'b1;
            state         <= StShiftHi;
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end

        StShiftHi: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt      <= '0;
            o_max7219_clk <= 1'b0;
            if (bit_cnt != BCNT_W'(1)) begin
              bit_cnt        <= bit_cnt - BCNT_W'(1);
              shift_reg      <= shift_reg << 1;
              o_max7219_data <= shift_reg[NB_BITS-2];
              state          <= StShiftLo;
            end else begin
              bit_cnt        <= '0;
              o_max7219_data <= 1'b0;
              if (en_load) begin
                o_max7219_load <= 1'b1;
                state          <= StLoad;
              end else begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                state  <= StDone;
              end
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end

        StLoad: begin
          if (tick_cnt == LOAD_LAST) begin
            tick_cnt       <= '0;
            o_max7219_load <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b1;
            state          <= StDone;
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end

        StDone: begin
          // A start arriving here is dropped: the FSM is not idle yet.
          o_done <= 1'b0;
          state  <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_chain_if.sv
module tb_max7219_chain_if;

  localparam int unsigned NDEV  = 4;
  localparam int unsigned HALF  = 4;
  localparam int unsigned LDUR  = 4;
  localparam int unsigned NBITS = 16 * NDEV;
  localparam int unsigned NBW   = $clog2(NDEV + 1);

  logic             clk;
  logic             rst_n;
  logic             i_start;
  logic             i_en_load;
  logic [NBW-1:0]   i_nb_dev;
  logic [NBITS-1:0] i_data;
  logic             o_max7219_load;
  logic             o_max7219_data;
  logic             o_max7219_clk;
  logic             o_busy;
  logic             o_done;

  max7219_chain_if #(
    .G_NB_DEVICES     (NDEV),
    .G_MAX_HALF_PERIOD(HALF),
    .G_LOAD_DURATION  (LDUR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_en_load     (i_en_load),
    .i_nb_dev      (i_nb_dev),
    .i_data        (i_data),
    .o_max7219_load(o_max7219_load),
    .o_max7219_data(o_max7219_data),
    .o_max7219_clk (o_max7219_clk),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] bits;
    int          nclk;
    bit          load;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the device count rule, the MSB-first stream of the farthest active
  // device first, and the start->done latency formula.
  function automatic exp_t model(input logic [NBW-1:0] nb, input logic [63:0] d, input bit ld,
                                 input int st);
    exp_t e;
    int n;
    n = (nb == 0 || nb > NDEV) ? NDEV : int'(nb);
    e.bits = '0;
    for (int k = n - 1; k >= 0; k--) begin
      e.bits = (e.bits << 16) | 64'(d[16*k +: 16]);
    end
    e.nclk      = 16 * n;
    e.load      = ld;
    e.lat       = 1 + 32 * n * HALF + (ld ? LDUR : 0);
    e.start_cyc = st;
    return e;
  endfunction

  // Monitor: reconstructs frames from the pins and checks them on each o_done.
  initial begin
    logic [63:0] rx;
    int nclk, lpulses, lhigh;
    bit prev_clk, prev_load;
    exp_t e;
    rx = '0; nclk = 0; lpulses = 0; lhigh = 0; prev_clk = 0; prev_load = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx = '0; nclk = 0; lpulses = 0; lhigh = 0; prev_clk = 0; prev_load = 0;
      end else begin
        if (o_max7219_clk && !prev_clk) begin
          rx = {rx[62:0], o_max7219_data};
          nclk++;
        end
        if (o_max7219_load) begin
          lhigh++;
          if (!prev_load) lpulses++;
          chk("clk_low_during_load", 64'(o_max7219_clk), 64'd0);
        end
        if (o_done) begin
          chk("busy_low_with_done", 64'(o_busy), 64'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bits", rx, e.bits);
            chk("clk_pulses", 64'(nclk), 64'(e.nclk));
            chk("load_pulses", 64'(lpulses), e.load ? 64'd1 : 64'd0);
            chk("load_cycles", 64'(lhigh), e.load ? 64'(LDUR) : 64'd0);
            chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
          end
          rx = '0; nclk = 0; lpulses = 0; lhigh = 0;
        end
        prev_clk  = o_max7219_clk;
        prev_load = o_max7219_load;
      end
    end
  end

  task automatic issue(input logic [NBW-1:0] nb, input logic [63:0] d, input bit ld,
                       input bit expect_frame);
    @(negedge clk);
    i_start   = 1'b1;
    i_nb_dev  = nb;
    i_data    = d;
    i_en_load = ld;
    if (expect_frame) exp_q.push_back(model(nb, d, ld, cyc));
    @(negedge clk);
    i_start   = 1'b0;
    // Scramble inputs mid-frame; the captured frame must not change.
    i_data    = {$urandom, $urandom};
    i_nb_dev  = NBW'($urandom_range(0, 7));
    i_en_load = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("frame_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int guard;
    int rises;
    bit pclk;
    rst_n = 1'b0; i_start = 1'b0; i_en_load = 1'b0; i_nb_dev = '0; i_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_load", 64'(o_max7219_load), 64'd0);
    chk("reset_data", 64'(o_max7219_data), 64'd0);
    chk("reset_clk", 64'(o_max7219_clk), 64'd0);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames.
    issue(NBW'(1), 64'h0000_0000_0000_A5C3, 1'b1, 1'b1);
    chk("busy_after_start", 64'(o_busy), 64'd1);
    wait_drain();
    issue(NBW'(0), 64'h0F01_0E02_0D03_0C04, 1'b1, 1'b1);
    wait_drain();
    issue(NBW'(2), 64'hFFFF_FFFF_1234_5678, 1'b1, 1'b1);
    wait_drain();
    issue(NBW'(1), 64'hDEAD_BEEF_CAFE_0C01, 1'b0, 1'b1);
    wait_drain();
    issue(NBW'(7), 64'h1111_2222_3333_4444, 1'b0, 1'b1);
    wait_drain();

    // Starts while busy and on the done cycle are dropped.
    issue(NBW'(1), 64'h0000_0000_0000_0C01, 1'b1, 1'b1);
    repeat (7) @(negedge clk);
    issue(NBW'(3), 64'h5555_6666_7777_8888, 1'b1, 1'b0);
    guard = 0;
    while (!o_done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!o_done) chk("done_timeout", 64'd1, 64'd0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_frame_after_ignored_start", 64'(o_busy), 64'd0);
    wait_drain();

    // Reset after the 5th CLK rising edge.
    issue(NBW'(1), 64'h0000_0000_0000_FFFF, 1'b1, 1'b1);
    rises = 0; pclk = 1'b0; guard = 0;
    while (rises < 5 && guard < 2000) begin
      @(negedge clk);
      if (o_max7219_clk && !pclk) rises++;
      pclk = o_max7219_clk;
      guard++;
    end
    chk("reset_test_rises", 64'(rises), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_clk", 64'(o_max7219_clk), 64'd0);
    chk("midreset_data", 64'(o_max7219_data), 64'd0);
    chk("midreset_load", 64'(o_max7219_load), 64'd0);
    chk("midreset_busy", 64'(o_busy), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    issue(NBW'(1), 64'h0000_0000_0000_0900, 1'b1, 1'b1);
    wait_drain();

    // Randomized frames.
    for (int i = 0; i < 10; i++) begin
      issue(NBW'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    repeat (30) @(negedge clk);
    chk("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    chk("idle_at_end", 64'(o_busy), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
